sprite_draw_engine: RTL and testbench

Draw stage directly downstream of the sprite queue. The queue first pulses UPDATE to load a sprite ID and anchor. It then holds RUN_ENG. The engine walks every pixel of the sprite, reads it from the sprite ROM, skips transparent and off-screen pixels, writes the rest to the frame buffer, and returns a single-cycle ENG_DONE pulse.

---
 rtl/sprite_pkg.sv | 26 ++
 rtl/sprite_pix_gen.sv | 66 ++++++
 rtl/sprite_draw_engine.sv | 118 +++++++++++
 tb/tb_sprite_draw_engine.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared sprite draw constants, state encoding and coordinate type.
// The optional SPRITE_FLIP_EN build adds horizontal mirroring in sprite_draw_engine.
package sprite_pkg;
   localparam int SPR_W   = 16;
   localparam int SPR_H   = 16;
   localparam int FB_W    = 320;
   localparam int FB_H    = 240;
   localparam int COLOR_W = 8;
   localparam logic [COLOR_W-1:0] TRANSP = 8'h00;
   localparam logic [1:0] SKIP_ID = 2'b11;

   localparam int ROW_W  = $clog2(SPR_H);
   localparam int COL_W  = $clog2(SPR_W);
   localparam int ROM_AW = 2 + ROW_W + COL_W;
   localparam int FB_AW  = 17;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARMED,
      ST_DRAW,
      ST_FLUSH,
      ST_DONE
   } eng_state_t;

   typedef logic [8:0] coord_t;
endpackage

// File: rtl/sprite_pix_gen.sv
// Sprite pixel walker: row-major counters plus one registered stage holding
// the clip decision and frame buffer address of the pixel just issued.
module sprite_pix_gen
   import sprite_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_srst,
   input  logic             i_clr,
   input  logic             i_adv,
   input  coord_t           i_x,
   input  coord_t           i_y,
   output logic [ROW_W-1:0] o_row,
   output logic [COL_W-1:0] o_col,
   output logic             o_last,
   output logic             o_valid,
   output logic             o_clip,
   output logic [FB_AW-1:0] o_fb_addr
);
   logic [ROW_W-1:0] r_row;
   logic [COL_W-1:0] r_col;
   logic             r_valid;
   logic             r_clip;
   logic [FB_AW-1:0] r_fb_addr;
   logic [9:0]       w_sx;
   logic [9:0]       w_sy;
   logic             w_clip;
   logic [FB_AW-1:0] w_addr;

   // Screen coordinates are 10 bits wide so anchors near 511 never wrap back on screen.
   assign w_sx   = {1'b0, i_x} + 10'(r_col);
   assign w_sy   = {1'b0, i_y} + 10'(r_row);
   assign w_clip = (w_sx >= 10'(FB_W)) || (w_sy >= 10'(FB_H));
   assign w_addr = FB_AW'(w_sy) * FB_AW'(FB_W) + FB_AW'(w_sx);

   always_ff @(posedge i_clk) begin
      if (i_srst) begin
         r_row     <= '0;
         r_col     <= '0;
         r_valid   <= 1'b0;
         r_clip    <= 1'b0;
         r_fb_addr <= '0;
      end else begin
         r_valid   <= i_adv;
         r_clip    <= w_clip;
         r_fb_addr <= w_addr;
         if (i_clr) begin
            r_row <= '0;
            r_col <= '0;
         end else if (i_adv) begin
            if (r_col == COL_W'(SPR_W - 1)) begin
               r_col <= '0;
               r_row <= r_row + ROW_W'(1);
            end else begin
               r_col <= r_col + COL_W'(1);
            end
         end
      end
   end

   assign o_row     = r_row;
   assign o_col     = r_col;
   assign o_last    = (r_row == ROW_W'(SPR_H - 1)) && (r_col == COL_W'(SPR_W - 1));
   assign o_valid   = r_valid;
   assign o_clip    = r_clip;
   assign o_fb_addr = r_fb_addr;
endmodule

// File: rtl/sprite_draw_engine.sv
// Sprite draw stage: latches a sprite request, walks its pixels through the ROM and
// writes opaque on-screen pixels. Define SPRITE_FLIP_EN to add the FLIP_H mirror input.
module sprite_draw_engine
   import sprite_pkg::*;
(
   input  logic               CLOCK_50,
   input  logic               RESET_H,
   input  logic               UPDATE,
   input  logic               RUN_ENG,
   input  logic [1:0]         SPRITE_ID,
   input  coord_t             TARGET_X,
   input  coord_t             TARGET_Y,
`ifdef SPRITE_FLIP_EN
   input  logic               FLIP_H,
`endif
   output logic [ROM_AW-1:0]  ROM_ADDR,
   input  logic [COLOR_W-1:0] ROM_DATA,
   output logic [FB_AW-1:0]   FB_ADDR,
   output logic [COLOR_W-1:0] FB_DATA,
   output logic               FB_WE,
   output logic               ENG_DONE,
   output logic               BUSY
);
   eng_state_t       r_state;
   eng_state_t       w_state_next;
   logic [1:0]       r_id;
   coord_t           r_x;
   coord_t           r_y;
   logic             r_loaded;
   logic             r_flip;
   logic             w_adv;
   logic             w_clr;
   logic             w_latch;
   logic [ROW_W-1:0] w_row;
   logic [COL_W-1:0] w_col;
   logic [COL_W-1:0] w_rom_col;
   logic             w_last;
   logic             w_valid;
   logic             w_clip;
   logic [FB_AW-1:0] w_fb_addr;

   always_ff @(posedge CLOCK_50) begin
      if (RESET_H) r_state <= ST_IDLE;
      else         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  if (UPDATE) w_state_next = ST_ARMED;
         ST_ARMED: begin
            if (!UPDATE && RUN_ENG && r_loaded)
               w_state_next = (r_id == SKIP_ID) ? ST_DONE : ST_DRAW;
         end
         ST_DRAW:  if (w_last) w_state_next = ST_FLUSH;
         ST_FLUSH: w_state_next = ST_DONE;
         ST_DONE:  w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_adv    = (r_state == ST_DRAW);
      w_clr    = (r_state == ST_ARMED);
      w_latch  = UPDATE && ((r_state == ST_IDLE) || (r_state == ST_ARMED));
      ENG_DONE = (r_state == ST_DONE);
      BUSY     = (r_state == ST_DRAW) || (r_state == ST_FLUSH) || (r_state == ST_DONE);
   end

   // Request registers only move while idle or armed, so a draw sees a frozen anchor.
   always_ff @(posedge CLOCK_50) begin
      if (RESET_H) begin
         r_id     <= '0;
         r_x      <= '0;
         r_y      <= '0;
         r_loaded <= 1'b0;
         r_flip   <= 1'b0;
      end else begin
         if (w_latch) begin
            r_id     <= SPRITE_ID;
            r_x      <= TARGET_X;
            r_y      <= TARGET_Y;
            r_loaded <= 1'b1;
`ifdef SPRITE_FLIP_EN
            r_flip   <= FLIP_H;
`else
            r_flip   <= 1'b0;
`endif
         end else if (r_state == ST_DONE) begin
            r_loaded <= 1'b0;
         end
      end
   end

   sprite_pix_gen u_pix_gen (
      .i_clk     (CLOCK_50),
      .i_srst    (RESET_H),
      .i_clr     (w_clr),
      .i_adv     (w_adv),
      .i_x       (r_x),
      .i_y       (r_y),
      .o_row     (w_row),
      .o_col     (w_col),
      .o_last    (w_last),
      .o_valid   (w_valid),
      .o_clip    (w_clip),
      .o_fb_addr (w_fb_addr)
   );

   // SPR_W is a power of two, so SPR_W-1-col is the bitwise inverse of col.
   assign w_rom_col = r_flip ? ~w_col : w_col;
   assign ROM_ADDR  = {r_id, w_row, w_rom_col};

   // ROM_DATA belongs to the pixel issued last cycle, aligned with the pix_gen stage.
   assign FB_WE   = w_valid && !w_clip && (ROM_DATA != TRANSP);
   assign FB_ADDR = w_fb_addr;
   assign FB_DATA = FB_WE ? ROM_DATA : '0;
endmodule

// File: tb/tb_sprite_draw_engine.sv
// Directed bench for sprite_draw_engine with a registered sprite ROM model.
// Build with SPRITE_FLIP_EN defined to also exercise the mirror path.
module tb_sprite_draw_engine;
   import sprite_pkg::*;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               update = 1'b0;
   logic               run_eng = 1'b0;
   logic [1:0]         sprite_id = 2'b00;
   logic [8:0]         target_x = '0;
   logic [8:0]         target_y = '0;
   logic [ROM_AW-1:0]  rom_addr;
   logic [COLOR_W-1:0] rom_q = '0;
   logic [FB_AW-1:0]   fb_addr;
   logic [COLOR_W-1:0] fb_data;
   logic               fb_we;
   logic               eng_done;
   logic               busy;
`ifdef SPRITE_FLIP_EN
   logic               flip_h = 1'b0;
`endif

   logic [7:0] rom [0:1023];

   int checks = 0;
   int errors = 0;

   int wr_cnt, first_addr, last_addr, first_data, even_sx, oob;
   int done_cnt, done_cyc, dbl_done, busy5, busy_end, we_after_rst;

   always #5 clk = ~clk;

   always @(posedge clk) rom_q <= rom[rom_addr];

   sprite_draw_engine dut (
      .CLOCK_50  (clk),
      .RESET_H   (rst),
      .UPDATE    (update),
      .RUN_ENG   (run_eng),
      .SPRITE_ID (sprite_id),
      .TARGET_X  (target_x),
      .TARGET_Y  (target_y),
`ifdef SPRITE_FLIP_EN
      .FLIP_H    (flip_h),
`endif
      .ROM_ADDR  (rom_addr),
      .ROM_DATA  (rom_q),
      .FB_ADDR   (fb_addr),
      .FB_DATA   (fb_data),
      .FB_WE     (fb_we),
      .ENG_DONE  (eng_done),
      .BUSY      (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // mode 0: all 5, mode 1: transparent at even cols, mode 2: value = col index
   task automatic fill_rom(input int mode);
      for (int i = 0; i < 1024; i++) begin
         case (mode)
            0:       rom[i] = 8'h05;
            1:       rom[i] = (i % 2 == 0) ? 8'h00 : 8'h05;
            default: rom[i] = 8'(i % 16);
         endcase
      end
   endtask

   // Load a request, hold RUN_ENG until ENG_DONE, and log writes for ncyc cycles.
   task automatic run_draw(input logic [1:0] id, input int x, input int y,
                           input int upd_at, input int rst_at, input int ncyc);
      int c;
      int prev_done;
      wr_cnt = 0; first_addr = -1; last_addr = -1; first_data = -1;
      even_sx = 0; oob = 0; done_cnt = 0; done_cyc = -1; dbl_done = 0;
      busy5 = 0; busy_end = 0; we_after_rst = -1; prev_done = 0;
      @(negedge clk);
      update = 1'b1; sprite_id = id; target_x = 9'(x); target_y = 9'(y);
      @(negedge clk);
      update = 1'b0; run_eng = 1'b1;
      c = 0;
      while (c < ncyc) begin
         @(negedge clk);
         c++;
         if (fb_we) begin
            if (wr_cnt == 0) begin
               first_addr = int'(fb_addr);
               first_data = int'(fb_data);
            end
            last_addr = int'(fb_addr);
            wr_cnt++;
            if ((int'(fb_addr) % 320) % 2 == 0) even_sx++;
            if (int'(fb_addr) >= 76800) oob++;
         end
         if (eng_done) begin
            done_cnt++;
            done_cyc = c;
            run_eng = 1'b0;
            if (prev_done != 0) dbl_done++;
         end
         prev_done = eng_done ? 1 : 0;
         if (c == 5) busy5 = busy ? 1 : 0;
         busy_end = busy ? 1 : 0;
         if (c == upd_at) begin
            update = 1'b1; target_x = 9'd100; target_y = 9'd100;
         end else begin
            update = 1'b0;
         end
         if (c == rst_at) begin
            rst = 1'b1;
         end else if (c == rst_at + 1) begin
            rst = 1'b0;
            we_after_rst = fb_we ? 1 : 0;
            run_eng = 1'b0;
         end
      end
      run_eng = 1'b0;
      update = 1'b0;
   endtask

   initial begin
      int idle_act;
      fill_rom(0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_eng_done", 32'(eng_done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_fb_we", 32'(fb_we), 32'd0);
      chk("rst_rom_addr", 32'(rom_addr), 32'd0);
      chk("rst_fb_addr", 32'(fb_addr), 32'd0);
      chk("rst_fb_data", 32'(fb_data), 32'd0);

      // Opaque sprite at (10,20)
      run_draw(2'd0, 10, 20, -1, -1, 262);
      $display("draw opaque x=10 y=20: writes=%0d first=%0d last=%0d done_cyc=%0d",
               wr_cnt, first_addr, last_addr, done_cyc);
      chk("opaque_writes", 32'(wr_cnt), 32'd256);
      chk("opaque_first_addr", 32'(first_addr), 32'd6410);
      chk("opaque_last_addr", 32'(last_addr), 32'd11225);
      chk("opaque_first_data", 32'(first_data), 32'd5);
      chk("opaque_done_cyc", 32'(done_cyc), 32'd258);
      chk("opaque_done_cnt", 32'(done_cnt), 32'd1);
      chk("opaque_done_wide", 32'(dbl_done), 32'd0);
      chk("opaque_busy_mid", 32'(busy5), 32'd1);
      chk("opaque_busy_end", 32'(busy_end), 32'd0);

      // Transparent even columns
      fill_rom(1);
      run_draw(2'd0, 10, 20, -1, -1, 262);
      $display("draw transp-even: writes=%0d even_sx=%0d done_cyc=%0d", wr_cnt, even_sx, done_cyc);
      chk("transp_writes", 32'(wr_cnt), 32'd128);
      chk("transp_even_sx", 32'(even_sx), 32'd0);
      chk("transp_done_cyc", 32'(done_cyc), 32'd258);

      // Bottom-right clipping
      fill_rom(0);
      run_draw(2'd1, 312, 232, -1, -1, 262);
      $display("draw clip x=312 y=232: writes=%0d first=%0d last=%0d oob=%0d done_cyc=%0d",
               wr_cnt, first_addr, last_addr, oob, done_cyc);
      chk("clip_writes", 32'(wr_cnt), 32'd64);
      chk("clip_oob", 32'(oob), 32'd0);
      chk("clip_first_addr", 32'(first_addr), 32'd74552);
      chk("clip_last_addr", 32'(last_addr), 32'd76799);
      chk("clip_done_cyc", 32'(done_cyc), 32'd258);

      // Skip code
      run_draw(2'd3, 10, 20, -1, -1, 20);
      $display("draw skip id=3: writes=%0d done_cyc=%0d done_cnt=%0d", wr_cnt, done_cyc, done_cnt);
      chk("skip_writes", 32'(wr_cnt), 32'd0);
      chk("skip_done_cyc", 32'(done_cyc), 32'd1);
      chk("skip_done_cnt", 32'(done_cnt), 32'd1);
      chk("skip_busy_end", 32'(busy_end), 32'd0);

      // RUN_ENG without UPDATE
      idle_act = 0;
      run_eng = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (fb_we || eng_done || busy) idle_act++;
      end
      run_eng = 1'b0;
      $display("run without update: active_cycles=%0d", idle_act);
      chk("noupd_activity", 32'(idle_act), 32'd0);

      // UPDATE during DRAW is ignored
      run_draw(2'd0, 10, 20, 100, -1, 262);
      $display("draw with late update: writes=%0d first=%0d last=%0d done_cyc=%0d",
               wr_cnt, first_addr, last_addr, done_cyc);
      chk("lateupd_writes", 32'(wr_cnt), 32'd256);
      chk("lateupd_first_addr", 32'(first_addr), 32'd6410);
      chk("lateupd_last_addr", 32'(last_addr), 32'd11225);
      chk("lateupd_done_cyc", 32'(done_cyc), 32'd258);

      // Reset mid-draw
      run_draw(2'd0, 10, 20, -1, 50, 300);
      $display("draw reset at 50: writes=%0d we_after=%0d done_cnt=%0d busy_end=%0d",
               wr_cnt, we_after_rst, done_cnt, busy_end);
      chk("rstmid_we_after", 32'(we_after_rst), 32'd0);
      chk("rstmid_writes", 32'(wr_cnt), 32'd49);
      chk("rstmid_done_cnt", 32'(done_cnt), 32'd0);
      chk("rstmid_busy_end", 32'(busy_end), 32'd0);

`ifdef SPRITE_FLIP_EN
      fill_rom(2);
      flip_h = 1'b1;
      run_draw(2'd1, 0, 0, -1, -1, 262);
      flip_h = 1'b0;
      $display("draw flipped x=0 y=0: writes=%0d first=%0d first_data=%0d", wr_cnt, first_addr, first_data);
      chk("flip_first_addr", 32'(first_addr), 32'd0);
      chk("flip_first_data", 32'(first_data), 32'd15);
      chk("flip_writes", 32'(wr_cnt), 32'd240);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
